// File: rtl/axi4_slave_write_ctrl_if.sv
// Interface bundle for the slave write controller.
// Purpose: groups the command, W, memory-write and B channel signals so that
// the controller and its neighbours connect through one port.
// Signals:
//   cmd_*    captured AW command from the address stage (valid/ready handshake)
//   w*       AXI W channel beats
//   mem_*    registered write port toward the slave memory array
//   b*       AXI B write response channel
//   busy     controller is inside a transaction (DATA or RESP)
// Modports:
//   slave    the write controller itself
//   master   everything that surrounds it (AW stage, W/B master, memory)
interface axi4_slave_write_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [ID_WIDTH-1:0]   cmd_id;
  logic [7:0]            cmd_len;
  logic [2:0]            cmd_size;
  logic [1:0]            cmd_burst;

  logic                  wvalid;
  logic                  wready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [STRB_WIDTH-1:0] mem_wstrb;

  logic                  bvalid;
  logic                  bready;
  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;

  logic                  busy;

  modport slave (
    input  cmd_valid, cmd_addr, cmd_id, cmd_len, cmd_size, cmd_burst,
    output cmd_ready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output mem_we, mem_addr, mem_wdata, mem_wstrb,
    output bvalid, bid, bresp,
    input  bready,
    output busy
  );

  modport master (
    output cmd_valid, cmd_addr, cmd_id, cmd_len, cmd_size, cmd_burst,
    input  cmd_ready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  bvalid, bid, bresp,
    output bready,
    input  busy
  );

endinterface

// File: rtl/axi4_slave_write_ctrl.sv
// AXI4 slave write controller.
// Purpose: sequences one write transaction at a time. Accepts a captured AW
// command, generates per-beat addresses (FIXED/INCR/WRAP), gates the W
// channel, drives a registered memory write port one clock after each beat
// handshake, and finally returns the B response.
// Ports:
//   clk   clock, all logic on the rising edge
//   rst   asynchronous reset, active low
//   bus   axi4_slave_write_ctrl_if.slave (command, W, memory, B, busy)
module axi4_slave_write_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input logic                    clk,
  input logic                    rst,
  axi4_slave_write_ctrl_if.slave bus
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int MAX_SIZE   = $clog2(STRB_WIDTH);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state;

  logic [ADDR_WIDTH-1:0] start_addr;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic [ID_WIDTH-1:0]   id_q;
  logic [7:0]            len_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic [7:0]            beat_cnt;
  logic                  err;

  logic                  cmd_ready_q;
  logic                  wready_q;
  logic                  bvalid_q;
  logic                  busy_q;
  logic [1:0]            bresp_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [STRB_WIDTH-1:0] mem_wstrb_q;

  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] wrap_bound;
  logic [ADDR_WIDTH-1:0] wrap_low;
  logic [ADDR_WIDTH-1:0] wrap_sum;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  cmd_err;
  logic                  beat;
  logic                  cnt_done;
  logic                  last_beat;
  logic                  end_err;

  // Address of the beat after the current one. The wrap window is derived
  // from the latched start address, so it stays fixed for the whole burst.
  // INCR masks the low bits before adding, which realigns an unaligned start
  // address after the first beat; the reserved burst type shares this path
  // because its data is never written anyway.
  always_comb begin
    incr       = ADDR_WIDTH'(1) << size_q;
    wrap_bound = ADDR_WIDTH'({1'b0, len_q} + 9'd1) << size_q;
    wrap_low   = start_addr & ~(wrap_bound - ADDR_WIDTH'(1));
    wrap_sum   = beat_addr + incr;
    next_addr  = beat_addr;
    case (burst_q)
      BURST_FIXED: next_addr = beat_addr;
      BURST_WRAP:  next_addr = (wrap_sum == wrap_low + wrap_bound) ? wrap_low : wrap_sum;
      default:     next_addr = (beat_addr & ~(incr - ADDR_WIDTH'(1))) + incr;
    endcase
  end

  // Command legality, judged on the incoming command at accept time:
  // reserved burst type, beat wider than the data bus, or a WRAP length
  // that is not 2, 4, 8 or 16 beats.
  always_comb begin
    cmd_err = 1'b0;
    if (bus.cmd_burst == BURST_RSVD)
      cmd_err = 1'b1;
    if (int'(bus.cmd_size) > MAX_SIZE)
      cmd_err = 1'b1;
    if (bus.cmd_burst == BURST_WRAP && !(bus.cmd_len inside {8'd1, 8'd3, 8'd7, 8'd15}))
      cmd_err = 1'b1;
  end

  // Beat bookkeeping. A burst ends on wlast or on the expected beat count,
  // whichever arrives first; if the two disagree the master and the command
  // are out of step and the response becomes SLVERR.
  always_comb begin
    beat      = bus.wvalid && wready_q;
    cnt_done  = (beat_cnt == len_q);
    last_beat = bus.wlast || cnt_done;
    end_err   = err || (bus.wlast != cnt_done);
  end

  // Main FSM. Handshake outputs are registered and updated alongside the
  // state so they always reflect the state the controller is in, while still
  // reading 0 during reset. cmd_ready is re-raised on the B handshake edge,
  // which leaves the handshake cycle itself unable to accept a new command.
  // Writes use the error flag from accept time, so beats of a burst that is
  // only found bad at its end are still written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      start_addr  <= '0;
      beat_addr   <= '0;
      id_q        <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      beat_cnt    <= '0;
      err         <= 1'b0;
      cmd_ready_q <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      busy_q      <= 1'b0;
      bresp_q     <= RESP_OKAY;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      mem_we_q <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (bus.cmd_valid && cmd_ready_q) begin
            start_addr  <= bus.cmd_addr;
            beat_addr   <= bus.cmd_addr;
            id_q        <= bus.cmd_id;
            len_q       <= bus.cmd_len;
            size_q      <= bus.cmd_size;
            burst_q     <= bus.cmd_burst;
            beat_cnt    <= '0;
            err         <= cmd_err;
            cmd_ready_q <= 1'b0;
            wready_q    <= 1'b1;
            busy_q      <= 1'b1;
            state       <= DATA;
          end
        end
        DATA: begin
          if (beat) begin
            mem_we_q    <= !err;
            mem_addr_q  <= beat_addr;
            mem_wdata_q <= bus.wdata;
            mem_wstrb_q <= bus.wstrb;
            beat_addr   <= next_addr;
            beat_cnt    <= beat_cnt + 8'd1;
            if (last_beat) begin
              err      <= end_err;
              bresp_q  <= end_err ? RESP_SLVERR : RESP_OKAY;
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              state    <= RESP;
            end
          end
        end
        RESP: begin
          if (bus.bready) begin
            err         <= 1'b0;
            bresp_q     <= RESP_OKAY;
            bvalid_q    <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.wready    = wready_q;
  assign bus.bvalid    = bvalid_q;
  assign bus.bid       = id_q;
  assign bus.bresp     = bresp_q;
  assign bus.busy      = busy_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wstrb = mem_wstrb_q;

endmodule
